mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: 16/32-bit loads, stores, pushes and pops against a
// 16-bit-wide internal data memory. 32-bit accesses take two beats and stall upstream.
module mem_access_unit #(
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic              i_isStack,
  input  logic              i_en32,
  input  logic [15:0]       i_aluData,
  input  logic [31:0]       i_writeData,
  input  logic [3:0]        i_wb,
  input  logic [2:0]        i_Rdst,
  output logic              o_stall,
  output logic              o_valid,
  output logic [31:0]       o_memData,
  output logic [15:0]       o_aluData,
  output logic [3:0]        o_wb,
  output logic [2:0]        o_Rdst,
  output logic [ADDR_W-1:0] o_sp
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, BEAT2} state_t;

  logic [15:0]       mem [DEPTH];

  state_t            state, state_d;
  logic [ADDR_W-1:0] sp, sp_d;

  // Operands captured at acceptance of a 32-bit access, used by the second beat
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wd;
  logic              lat_write;
  logic              lat_stack;
  logic [15:0]       lat_alu;
  logic [3:0]        lat_wb;
  logic [2:0]        lat_rdst;
  logic [15:0]       low_q, low_d;
  logic              latch_en;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rdata;
  logic [ADDR_W-1:0] a_in;

  logic              valid_d;
  logic [31:0]       data_d;
  logic [15:0]       alu_d;
  logic [3:0]        wb_d;
  logic [2:0]        rdst_d;

  assign a_in = i_aluData[ADDR_W-1:0];
  assign o_sp = sp;

  // Pops always read one above SP; plain 32-bit loads read the upper word in beat 2
  always_comb begin
    if (state == IDLE) begin
      rd_addr = i_isStack ? sp + ADDR_W'(1) : a_in;
    end else begin
      rd_addr = lat_stack ? sp + ADDR_W'(1) : lat_addr + ADDR_W'(1);
    end
  end

  assign rdata = mem[rd_addr];

  always_comb begin
    state_d  = state;
    sp_d     = sp;
    o_stall  = 1'b0;
    latch_en = 1'b0;
    low_d    = low_q;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    valid_d  = 1'b0;
    data_d   = o_memData;
    alu_d    = o_aluData;
    wb_d     = o_wb;
    rdst_d   = o_Rdst;

    unique case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_memWrite) begin
            we    = 1'b1;
            waddr = i_isStack ? sp : a_in;
            wdata = (i_isStack && i_en32) ? i_writeData[31:16] : i_writeData[15:0];
            if (i_isStack) sp_d = sp - ADDR_W'(1);
          end else if (i_memRead) begin
            if (i_isStack) sp_d = sp + ADDR_W'(1);
            low_d = rdata;
          end

          if ((i_memRead || i_memWrite) && i_en32) begin
            o_stall  = 1'b1;
            latch_en = 1'b1;
            state_d  = BEAT2;
          end else begin
            valid_d = 1'b1;
            alu_d   = i_aluData;
            wb_d    = i_wb;
            rdst_d  = i_Rdst;
            data_d  = (i_memRead && !i_memWrite) ? {16'h0000, rdata} : 32'h0;
          end
        end
      end

      BEAT2: begin
        state_d = IDLE;
        valid_d = 1'b1;
        alu_d   = lat_alu;
        wb_d    = lat_wb;
        rdst_d  = lat_rdst;
        if (lat_write) begin
          we     = 1'b1;
          waddr  = lat_stack ? sp : lat_addr + ADDR_W'(1);
          wdata  = lat_stack ? lat_wd[15:0] : lat_wd[31:16];
          data_d = 32'h0;
          if (lat_stack) sp_d = sp - ADDR_W'(1);
        end else begin
          data_d = {rdata, low_q};
          if (lat_stack) sp_d = sp + ADDR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sp        <= SP_RESET;
      o_valid   <= 1'b0;
      o_memData <= '0;
      o_aluData <= '0;
      o_wb      <= '0;
      o_Rdst    <= '0;
      lat_addr  <= '0;
      lat_wd    <= '0;
      lat_write <= 1'b0;
      lat_stack <= 1'b0;
      lat_alu   <= '0;
      lat_wb    <= '0;
      lat_rdst  <= '0;
      low_q     <= '0;
    end else begin
      state     <= state_d;
      sp        <= sp_d;
      o_valid   <= valid_d;
      o_memData <= data_d;
      o_aluData <= alu_d;
      o_wb      <= wb_d;
      o_Rdst    <= rdst_d;
      low_q     <= low_d;
      if (latch_en) begin
        lat_addr  <= a_in;
        lat_wd    <= i_writeData;
        lat_write <= i_memWrite;
        lat_stack <= i_isStack;
        lat_alu   <= i_aluData;
        lat_wb    <= i_wb;
        lat_rdst  <= i_Rdst;
      end
    end
  end

  // Memory is never cleared; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst && we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// compared against a word-array reference model of the memory and stack pointer.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_memRead, i_memWrite, i_isStack, i_en32;
  logic [15:0] i_aluData;
  logic [31:0] i_writeData;
  logic [3:0]  i_wb;
  logic [2:0]  i_Rdst;
  logic        o_stall, o_valid;
  logic [31:0] o_memData;
  logic [15:0] o_aluData;
  logic [3:0]  o_wb;
  logic [2:0]  o_Rdst;
  logic [10:0] o_sp;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_isStack(i_isStack), .i_en32(i_en32),
    .i_aluData(i_aluData), .i_writeData(i_writeData), .i_wb(i_wb), .i_Rdst(i_Rdst),
    .o_stall(o_stall), .o_valid(o_valid), .o_memData(o_memData),
    .o_aluData(o_aluData), .o_wb(o_wb), .o_Rdst(o_Rdst), .o_sp(o_sp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mem [2048];
  logic [10:0] m_sp;
  logic [31:0] e_data;
  logic [15:0] e_alu;
  logic [3:0]  e_wb;
  logic [2:0]  e_rdst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_isStack = 1'b0;
    i_en32 = 1'b0; i_aluData = '0; i_writeData = '0; i_wb = '0; i_Rdst = '0;
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid);
    chk({tag, "_valid"}, 32'(o_valid), 32'(exp_valid));
    chk({tag, "_data"},  o_memData, e_data);
    chk({tag, "_alu"},   32'(o_aluData), 32'(e_alu));
    chk({tag, "_wb"},    32'(o_wb), 32'(e_wb));
    chk({tag, "_rdst"},  32'(o_Rdst), 32'(e_rdst));
    chk({tag, "_sp"},    32'(o_sp), 32'(m_sp));
  endtask

  // Called at posedge+1; returns at posedge+1 after the result is visible
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic st,
                       input logic e32, input logic [15:0] alu, input logic [31:0] wd,
                       input logic [3:0] wb, input logic [2:0] rdst);
    logic        two;
    logic [10:0] a, sp0, mid;
    logic [31:0] data;
    i_valid = v; i_memRead = rd; i_memWrite = wr; i_isStack = st; i_en32 = e32;
    i_aluData = alu; i_writeData = wd; i_wb = wb; i_Rdst = rdst;
    two = v & (rd | wr) & e32;
    #1;
    chk("stall_accept", 32'(o_stall), 32'(two));

    sp0  = m_sp;
    a    = alu[10:0];
    data = 32'h0;
    if (v) begin
      if (wr) begin
        if (st) begin
          if (e32) begin
            m_mem[m_sp] = wd[31:16];
            m_mem[m_sp - 11'd1] = wd[15:0];
            m_sp = m_sp - 11'd2;
          end else begin
            m_mem[m_sp] = wd[15:0];
            m_sp = m_sp - 11'd1;
          end
        end else begin
          m_mem[a] = wd[15:0];
          if (e32) m_mem[a + 11'd1] = wd[31:16];
        end
      end else if (rd) begin
        if (st) begin
          if (e32) begin
            data = {m_mem[m_sp + 11'd2], m_mem[m_sp + 11'd1]};
            m_sp = m_sp + 11'd2;
          end else begin
            data = {16'h0, m_mem[m_sp + 11'd1]};
            m_sp = m_sp + 11'd1;
          end
        end else begin
          data = e32 ? {m_mem[a + 11'd1], m_mem[a]} : {16'h0, m_mem[a]};
        end
      end
    end

    if (two) begin
      mid = st ? (wr ? sp0 - 11'd1 : sp0 + 11'd1) : sp0;
      @(posedge clk); #1;
      // Second beat must ignore whatever is now on the inputs
      i_valid = 1'($urandom); i_memRead = 1'($urandom); i_memWrite = 1'($urandom);
      i_isStack = 1'($urandom); i_en32 = 1'($urandom); i_aluData = 16'($urandom);
      i_writeData = $urandom; i_wb = 4'($urandom); i_Rdst = 3'($urandom);
      #1;
      chk("stall_beat2", 32'(o_stall), 32'h0);
      chk("valid_beat2", 32'(o_valid), 32'h0);
      chk("sp_beat2", 32'(o_sp), 32'(mid));
    end

    if (v) begin
      e_data = data; e_alu = alu; e_wb = wb; e_rdst = rdst;
    end
    @(posedge clk); #1;
    idle_inputs();
    check_outputs("op", v);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    m_sp = 11'h7FF; e_data = '0; e_alu = '0; e_wb = '0; e_rdst = '0;
    check_outputs("reset", 1'b0);
    chk("reset_stall", 32'(o_stall), 32'h0);
    rst = 1'b1;
  endtask

  task automatic load16(input logic [10:0] a);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(a), 32'h0, 4'h0, 3'h0);
  endtask

  initial begin
    logic [31:0] wd;
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Give every word a known value so every later read has a defined expectation
    for (int i = 0; i < 2048; i++)
      do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(i), $urandom, 4'($urandom), 3'($urandom));

    // Store16 / load16
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0000BEEF, 4'h3, 3'h1);
    load16(11'h010);
    chk("load16_beef", o_memData, 32'h0000BEEF);

    // Store32 / load32, upper and lower halves checked individually
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h12345678, 4'h5, 3'h2);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 32'h0, 4'h6, 3'h3);
    chk("load32", o_memData, 32'h12345678);
    load16(11'h020);
    chk("mem20", o_memData, 32'h00005678);
    load16(11'h021);
    chk("mem21", o_memData, 32'h00001234);

    // Push32 then pop32 from reset
    do_reset();
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 32'hCAFEF00D, 4'h1, 3'h4);
    chk("push32_sp", 32'(o_sp), 32'h7FD);
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 32'h0, 4'h2, 3'h5);
    chk("pop32_sp", 32'(o_sp), 32'h7FF);
    chk("pop32_data", o_memData, 32'hCAFEF00D);

    // Pop16 wraps SP to 0, push16 wraps it back
    do_reset();
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 4'h7, 3'h6);
    chk("pop16_wrap_sp", 32'(o_sp), 32'h000);
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 32'h0000A5A5, 4'h8, 3'h7);
    chk("push16_wrap_sp", 32'(o_sp), 32'h7FF);

    // Reset during the second beat of a push32 aborts it
    do_reset();
    wd = 32'hDEAD_0BAD;
    i_valid = 1'b1; i_memWrite = 1'b1; i_isStack = 1'b1; i_en32 = 1'b1;
    i_writeData = wd; i_wb = 4'h9; i_Rdst = 3'h1;
    @(posedge clk); #1;
    m_mem[11'h7FF] = wd[31:16];
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 32'(o_valid), 32'h0);
    chk("abort_sp", 32'(o_sp), 32'h7FF);
    rst = 1'b1;
    m_sp = 11'h7FF; e_data = '0; e_alu = '0; e_wb = '0; e_rdst = '0;
    load16(11'h7FE);
    load16(11'h7FF);
    chk("abort_beat0_kept", o_memData, {16'h0, wd[31:16]});

    // Read and write together: write wins, data is zero
    do_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h00004321, 4'hA, 3'h2);
    chk("rw_data_zero", o_memData, 32'h0);
    load16(11'h030);
    chk("rw_mem30", o_memData, 32'h00004321);

    // Idle cycle and no-memory op
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 4'hF, 3'h7);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 32'h1111_2222, 4'hC, 3'h3);
    chk("nomem_data", o_memData, 32'h0);

    // Address wrap on a plain 32-bit store/load
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h07FF, 32'h9876_5432, 4'h1, 3'h1);
    load16(11'h000);
    chk("wrap_store32_hi", o_memData, 32'h00009876);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      do_op(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
